// File: rtl/uart_pkg.sv
// Shared UART types and constants for uart_drive and its buffering blocks.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_ODD  = 2'd1,
    PARITY_EVEN = 2'd2
  } uart_parity_e;

  typedef logic [UART_DATA_WIDTH-1:0] uart_byte_t;

  // Parity bit to transmit for a byte; 0 when parity is disabled.
  function automatic logic uart_parity_bit(input uart_byte_t b, input uart_parity_e mode);
    logic p;
    p = 1'b0;
    case (mode)
      PARITY_ODD:  p = ~(^b);
      PARITY_EVEN: p = ^b;
      default:     p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the loopback FIFO: synchronous write, asynchronous read.
// Read data follows raddr combinationally; no flow control, caller owns pointers.
// Write is unconditional when we is high; the caller decides whether a byte is accepted.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int P_DATA_WIDTH = UART_DATA_WIDTH,
  parameter int P_ADDR_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [P_ADDR_WIDTH-1:0] waddr,
  input  logic [P_DATA_WIDTH-1:0] wdata,
  input  logic [P_ADDR_WIDTH-1:0] raddr,
  output logic [P_DATA_WIDTH-1:0] rdata
);

  logic [P_DATA_WIDTH-1:0] mem [2**P_ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_loop_fifo.sv
// Byte FIFO between UART rx (no backpressure) and tx (valid/ready); build option UART_LOOP_FIFO_DROP_CNT_EN.
// Latency: a byte written at edge N is presented after edge N; pops expose the next entry with no bubble.
// Backpressure: none toward rx; bytes arriving while full without a pop are dropped and flagged.
module uart_loop_fifo
  import uart_pkg::*;
#(
  parameter int P_DATA_WIDTH = UART_DATA_WIDTH,
  parameter int P_DEPTH_LOG2 = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [P_DATA_WIDTH-1:0] i_rx_data,
  input  logic                    i_rx_valid,
  output logic [P_DATA_WIDTH-1:0] o_tx_data,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ready,
  output logic [P_DEPTH_LOG2:0]   o_level,
  output logic                    o_full,
  output logic                    o_empty,
  output logic                    o_overflow,
  input  logic                    i_clr_overflow,
  output logic [15:0]             o_drop_cnt
);

  localparam logic [P_DEPTH_LOG2:0]   LVL_FULL = (P_DEPTH_LOG2+1)'(2**P_DEPTH_LOG2);
  localparam logic [P_DEPTH_LOG2:0]   LVL_ONE  = (P_DEPTH_LOG2+1)'(1);
  localparam logic [P_DEPTH_LOG2-1:0] PTR_ONE  = P_DEPTH_LOG2'(1);

  logic [P_DEPTH_LOG2-1:0] wr_ptr;
  logic [P_DEPTH_LOG2-1:0] rd_ptr;
  logic [P_DEPTH_LOG2:0]   count;
  logic                    full;
  logic                    pop;
  logic                    wr_en;
  logic                    drop;
  logic                    overflow;

  assign full       = (count == LVL_FULL);
  assign o_tx_valid = (count != '0);
  assign pop        = o_tx_valid & i_tx_ready;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign wr_en      = i_rx_valid & (~full | pop);
  assign drop       = i_rx_valid & full & ~pop;

  assign o_level    = count;
  assign o_full     = full;
  assign o_empty    = ~o_tx_valid;
  assign o_overflow = overflow;

  uart_fifo_mem #(
    .P_DATA_WIDTH (P_DATA_WIDTH),
    .P_ADDR_WIDTH (P_DEPTH_LOG2)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (i_rx_data),
    .raddr (rd_ptr),
    .rdata (o_tx_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en, pop})
        2'b10:   count <= count + LVL_ONE;
        2'b01:   count <= count - LVL_ONE;
        default: count <= count;
      endcase
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (i_clr_overflow) begin
      overflow <= 1'b0;
    end
  end

`ifdef UART_LOOP_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop) begin
      if (i_clr_overflow)           drop_cnt <= 16'd1;
      else if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end else if (i_clr_overflow) begin
      drop_cnt <= '0;
    end
  end

  assign o_drop_cnt = drop_cnt;
`else
  assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_loop_fifo.sv
// Self-checking bench for uart_loop_fifo: directed scenarios plus random traffic against a queue model.
module tb_uart_loop_fifo;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        tx_ready;
  logic [4:0]  o_level;
  logic        o_full;
  logic        o_empty;
  logic        o_overflow;
  logic        clr_ovf;
  logic [15:0] o_drop_cnt;

  int n_chk;
  int n_err;
  int dut_pops;

  logic [7:0]  mq[$];
  bit          m_ovf;
  int          m_drops;

  uart_loop_fifo dut (
    .clk            (clk),
    .rst            (rst),
    .i_rx_data      (rx_data),
    .i_rx_valid     (rx_valid),
    .o_tx_data      (o_tx_data),
    .o_tx_valid     (o_tx_valid),
    .i_tx_ready     (tx_ready),
    .o_level        (o_level),
    .o_full         (o_full),
    .o_empty        (o_empty),
    .o_overflow     (o_overflow),
    .i_clr_overflow (clr_ovf),
    .o_drop_cnt     (o_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_drop_cnt();
`ifdef UART_LOOP_FIFO_DROP_CNT_EN
    return m_drops;
`else
    return 0;
`endif
  endfunction

  task automatic check_state();
    check_val("level", o_level, mq.size());
    check_val("full", o_full, mq.size() == DEPTH);
    check_val("empty", o_empty, mq.size() == 0);
    check_val("tx_valid", o_tx_valid, mq.size() > 0);
    check_val("overflow", o_overflow, m_ovf);
    check_val("drop_cnt", o_drop_cnt, exp_drop_cnt());
  endtask

  // One clock cycle: drive, check the head before the edge, update the model, check state after.
  task automatic step(input bit v, input logic [7:0] d, input bit r, input bit c);
    bit full_b;
    bit pop_b;
    bit drop_b;
    rx_valid = v;
    rx_data  = d;
    tx_ready = r;
    clr_ovf  = c;
    #1;
    if (mq.size() > 0) check_val("head_dat", o_tx_data, mq[0]);
    if (o_tx_valid && r) dut_pops++;
    full_b = (mq.size() == DEPTH);
    pop_b  = (mq.size() > 0) && r;
    drop_b = v && full_b && !pop_b;
    @(posedge clk);
    if (pop_b) void'(mq.pop_front());
    if (v && !drop_b) mq.push_back(d);
    if (drop_b) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    if (drop_b) m_drops = c ? 1 : ((m_drops < 65535) ? m_drops + 1 : 65535);
    else if (c) m_drops = 0;
    #1;
    check_state();
  endtask

  task automatic drain();
    for (int k = 0; k < 2 * DEPTH + 8 && mq.size() > 0; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check_val("drained_empty", o_empty, 1);
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < DEPTH; i++) step(1'b1, base + 8'(i), 1'b0, 1'b0);
  endtask

  initial begin
    n_chk = 0; n_err = 0; dut_pops = 0;
    m_ovf = 1'b0; m_drops = 0;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0; clr_ovf = 1'b0;
    #2;
    check_state();
    #10 rst = 1'b0;

    // in-order capture then back-to-back replay
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    check_val("lvl5", o_level, 5);
    check_val("head1", o_tx_data, 8'h01);
    drain();

    // overflow drops exactly one byte and leaves contents intact
    fill(8'h10);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    check_val("ovf_set", o_overflow, 1);
`ifdef UART_LOOP_FIFO_DROP_CNT_EN
    check_val("drop_one", o_drop_cnt, 1);
`else
    check_val("drop_off", o_drop_cnt, 0);
`endif
    drain();

    // clear vs. simultaneous drop, then clear alone
    fill(8'h20);
    step(1'b1, 8'hBB, 1'b0, 1'b0);
    step(1'b1, 8'hCC, 1'b0, 1'b1);
    check_val("clr_vs_drop", o_overflow, 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check_val("clr_alone", o_overflow, 0);
    check_val("clr_cnt", o_drop_cnt, 0);

    // full with simultaneous write and pop
    step(1'b1, 8'h55, 1'b1, 1'b0);
    check_val("full_wp_lvl", o_level, 16);
    check_val("full_wp_ovf", o_overflow, 0);
    drain();

    // streaming through pointer wrap
    dut_pops = 0;
    for (int i = 0; i < 40; i++) step(1'b1, 8'h40 + 8'(i), 1'b1, 1'b0);
    drain();
    check_val("stream_pops", dut_pops, 40);

    // random traffic with varying rate mismatch
    for (int ph = 0; ph < 3; ph++) begin
      int rxp;
      int rdp;
      rxp = (ph == 0) ? 80 : (ph == 1) ? 30 : 60;
      rdp = (ph == 0) ? 30 : (ph == 1) ? 80 : 60;
      for (int k = 0; k < 150; k++) begin
        step($urandom_range(0, 99) < rxp, 8'($urandom), $urandom_range(0, 99) < rdp,
             $urandom_range(0, 99) < 5);
      end
    end
    drain();

    // asynchronous reset with bytes queued and a pop in progress
    for (int i = 0; i < 7; i++) step(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
    tx_ready = 1'b1;
    rx_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_val("rst_level", o_level, 0);
    check_val("rst_valid", o_tx_valid, 0);
    check_val("rst_empty", o_empty, 1);
    mq.delete();
    m_ovf = 1'b0;
    m_drops = 0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    check_val("head_3c", o_tx_data, 8'h3C);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_loop_fifo.md
# uart_loop_fifo

Byte buffer between the UART receive and transmit paths of `uart_drive`. It captures every received byte from the no-backpressure `o_user_rx_data`/`o_user_rx_valid` output. It replays the bytes in order on the valid/ready transmit input `i_user_tx_data`/`i_user_tx_valid`/`o_user_tx_ready`. It absorbs rate mismatch between the two paths, detects overflow, and gives the board-level loopback/echo design a standing buffer.

## Interface
- `P_DATA_WIDTH`, 8, byte width; matches `P_UART_DATA_WIDTH` of `uart_drive`.
- `P_DEPTH_LOG2`, 4, log2 of the entry count; depth = 2^`P_DEPTH_LOG2` = 16.
- `clk`  in  1  system clock. Reset `rst` is asynchronous and active-high.
- `rst`  in  1  asynchronous, active-high reset.
- `i_rx_data`  in  `P_DATA_WIDTH`  received byte; from `o_user_rx_data`.
- `i_rx_valid`  in  1  one-cycle write strobe; from `o_user_rx_valid`; no backpressure.
- `o_tx_data`  out  `P_DATA_WIDTH`  head-of-queue byte; to `i_user_tx_data`.
- `o_tx_valid`  out  1  queue not empty; to `i_user_tx_valid`.
- `i_tx_ready`  in  1  from `o_user_tx_ready`; a pop occurs when `o_tx_valid & i_tx_ready`.
- `o_level`  out  `P_DEPTH_LOG2`+1  current entry count, 0..depth.
- `o_full`  out  1  `o_level` == depth.
- `o_empty`  out  1  `o_level` == 0.
- `o_overflow`  out  1  sticky flag: at least one byte was dropped.
- `i_clr_overflow`  in  1  synchronous clear of `o_overflow`.
- `o_drop_cnt`  out  16  number of dropped bytes (see Configuration).

## Operation
- Storage: circular array with write pointer `wr_ptr` and read pointer `rd_ptr`, each `P_DEPTH_LOG2` bits wide. Pointers wrap modulo depth with natural binary rollover. Occupancy is tracked by a separate `P_DEPTH_LOG2`+1-bit count register.
- Write: on `i_rx_valid`, the byte is stored at `wr_ptr` and `wr_ptr` increments. This happens only when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- Pop: `o_tx_valid & i_tx_ready` increments `rd_ptr`.
- Count update:
  - write only: +1.
  - pop only: −1.
  - both: unchanged.
  - neither: unchanged.
- Full with simultaneous write and pop: the write is accepted and the count stays at depth.
- Empty with `i_rx_valid`: no pop is possible because `o_tx_valid` = 0. The write is accepted.
- Overflow: `i_rx_valid` while full with no pop drops the byte. Pointers and count are unchanged, and `o_overflow` is set on the next edge.
- `i_clr_overflow` clears `o_overflow`. If a clear and a new drop occur in the same cycle, the set wins.
- `o_tx_data` = mem[`rd_ptr`] is a combinational read. It holds stable while `o_tx_valid` && !`i_tx_ready`.
- No separate FSM. Behaviour is fully determined by the pointers and count.

## Timing
- Reset values: `o_tx_valid` = 0, `o_empty` = 1, `o_full` = 0, `o_level` = 0, `o_overflow` = 0, `o_drop_cnt` = 0. Pointers reset to 0. Memory contents are not reset, so `o_tx_data` is don't-care while `o_tx_valid` = 0.
- Write-to-valid latency: a byte written at edge N into an empty FIFO gives `o_tx_valid` = 1 and valid `o_tx_data` after edge N.
- Pop-to-next-data latency: after the pop at edge M, the next entry is presented after edge M, with no bubble.
- `o_level`, `o_full`, `o_empty` and `o_tx_valid` are derived from the count register. They update on the same edge as the write or pop.
- Reset mid-operation: all queued bytes are discarded immediately (asynchronous). The first write after reset release behaves as the empty case.

## Configuration
- Macro: `UART_LOOP_FIFO_DROP_CNT_EN`.
- Defined: `o_drop_cnt` is a 16-bit counter. It increments on every dropped byte and saturates at 0xFFFF. `i_clr_overflow` also clears it, and a same-cycle drop takes precedence, giving a result of 1.
- Undefined: no counter logic is built and `o_drop_cnt` is tied to 0. `o_overflow` is unaffected.

## Structure
- Shared package `uart_pkg` holds:
  - `UART_DATA_WIDTH` = 8.
  - the parity enum (NONE=0, ODD=1, EVEN=2) used by `uart_drive`.
  - the `uart_byte_t` typedef.
- Sub-module `uart_fifo_mem`: a 2^N × `P_DATA_WIDTH` array with a synchronous write port and an asynchronous read port. It contains no control logic. `uart_loop_fifo` owns the pointers, count, flags and counter.

## Test plan
- Write 0x01..0x05 on consecutive cycles with `i_tx_ready` = 0 → `o_level` = 5, `o_tx_data` = 0x01. Then hold `i_tx_ready` = 1 → 0x01..0x05 appear on consecutive cycles, then `o_empty` = 1.
- Fill with 16 bytes, then write 0xAA with no pop → byte dropped, `o_overflow` = 1, `o_drop_cnt` = 1 (macro on) or 0 (macro off). A later drain shows the original 16 bytes unchanged.
- Full FIFO with a simultaneous write of 0x55 and a pop → `o_level` stays 16, no overflow. 0x55 is the last byte drained.
- Write 40 bytes while popping continuously with `i_tx_ready` = 1 → all 40 are received in order, and pointer wrap occurs with no loss.
- Set `o_overflow`, then assert `i_clr_overflow` in the same cycle as a new drop → `o_overflow` stays 1. Assert `i_clr_overflow` alone → 0, and `o_drop_cnt` = 0.
- Pulse `rst` with 7 bytes queued and a pop in progress → `o_level` = 0, `o_tx_valid` = 0 immediately. A subsequent write of 0x3C appears at the head.
